// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: four-way round-robin arbiter with one-hot grant decode and a hold timeout
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic [3:0] hold_cnt,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d, idx_q, idx_d, win, cand;
    logic [3:0] hold_q, hold_d, gnt_q, gnt_d;
    logic       timeout_q, timeout_d, release_c;
    always_comb begin
        win  = ptr_q;
        cand = ptr_q;
        // scan from the farthest offset down so the one nearest ptr wins
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req[cand]) win = cand;
        end
    end
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        release_c = done || !req[idx_q] || hold_q == 4'(MAX_HOLD - 1);
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = GRANT;
                idx_d   = win;
                hold_d  = 4'd0;
            end
        end else if (release_c) begin
            state_d   = IDLE;
            hold_d    = 4'd0;
            ptr_d     = idx_q + 2'd1;
            timeout_d = !done && req[idx_q];
        end else begin
            hold_d = hold_q + 4'd1;
        end
        gnt_d = state_d == GRANT ? 4'b0001 << idx_d : 4'b0000;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            idx_q     <= 2'd0;
            hold_q    <= 4'd0;
            gnt_q     <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = state_q == GRANT;
    assign hold_cnt  = hold_q;
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb_decoder_rr_arbiter: directed vectors for the round-robin arbiter with invariant checks each cycle
module tb_decoder_rr_arbiter;
    logic       clk = 0;
    logic       rst_n = 0;
    logic [3:0] req = 0;
    logic       done = 0;
    logic [3:0] gnt, hold_cnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid, timeout;
    int checks = 0, errors = 0;
    logic [3:0] seq [8];
    decoder_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .gnt(gnt),
        .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .hold_cnt(hold_cnt), .timeout(timeout)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_onehot0", 32'($onehot0(gnt)), 1);
            chk("inv_decode", 32'(!gnt_valid || gnt == (4'b0001 << gnt_idx)), 1);
            chk("inv_timeout", 32'(!(timeout && gnt_valid)), 1);
            chk("inv_hold", 32'(hold_cnt < 4'd8), 1);
        end
    end
    initial begin
        req = 4'b1111;
        @(negedge clk);
        step();
        step();
        chk("rst_gnt", gnt, 0);
        chk("rst_idx", gnt_idx, 0);
        chk("rst_valid", gnt_valid, 0);
        chk("rst_hold", hold_cnt, 0);
        chk("rst_to", timeout, 0);
        rst_n = 1;
        step();
        chk("first_gnt", gnt, 4'b0001);
        chk("first_idx", gnt_idx, 0);
        chk("first_valid", gnt_valid, 1);
        seq = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        done = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_gnt", gnt, seq[i]);
            chk("rr_to", timeout, 0);
            done = seq[i] != 0;
        end
        step();
        done = 0;
        req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("to_gnt", gnt, 4'b0100);
            chk("to_hold", hold_cnt, i);
            chk("to_early", timeout, 0);
        end
        step();
        chk("to_rel_gnt", gnt, 0);
        chk("to_pulse", timeout, 1);
        chk("to_rel_valid", gnt_valid, 0);
        step();
        chk("to_regnt", gnt, 4'b0100);
        chk("to_clear", timeout, 0);
        req = 4'b0000;
        step();
        chk("wd_idle", gnt, 0);
        req = 4'b0010;
        done = 1;
        step();
        done = 0;
        chk("idle_done_ignored", gnt, 4'b0010);
        step();
        step();
        chk("wd_hold2", hold_cnt, 2);
        req = 4'b1001;
        step();
        chk("wd_gnt", gnt, 0);
        chk("wd_to", timeout, 0);
        step();
        chk("wd_next", gnt, 4'b1000);
        for (int i = 0; i < 7; i++) step();
        chk("lim_hold", hold_cnt, 7);
        done = 1;
        step();
        done = 0;
        chk("lim_gnt", gnt, 0);
        chk("lim_to", timeout, 0);
        step();
        chk("lim_next", gnt, 4'b0001);
        req = 4'b0000;
        step();
        req = 4'b0100;
        step();
        step();
        step();
        step();
        chk("mid_gnt", gnt, 4'b0100);
        chk("mid_hold", hold_cnt, 3);
        rst_n = 0;
        req = 4'b1100;
        step();
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_valid", gnt_valid, 0);
        chk("mid_rst_hold", hold_cnt, 0);
        chk("mid_rst_to", timeout, 0);
        rst_n = 1;
        step();
        chk("post_rst_gnt", gnt, 4'b0100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
